// File: rtl/cpu_clk_gen.sv
// CPU clock generator.
// Derives the shared clk28 enable strobes (ck14/ck7/ck35) from a 3-bit phase
// counter. It also produces a registered CPU clock at 3.5/7/14 MHz. The CPU
// clock can be stretched high by wait_req, with a timeout so that a stuck wait
// source cannot stall the CPU forever.
module cpu_clk_gen #(
  parameter int WAIT_TIMEOUT = 255  // max clk28 cycles clkcpu may be held (1..1023)
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic [1:0] turbo_req,
  input  logic       wait_req,
  input  logic       clr_err,
  output logic       ck14,
  output logic       ck7,
  output logic       ck35,
  output logic       clkcpu,
  output logic       cpu_rise,
  output logic       cpu_fall,
  output logic [1:0] turbo_active,
  output logic       wait_active,
  output logic       wait_err
);

  localparam int             CW        = 10;
  localparam logic [CW-1:0]  WAIT_LAST = CW'(WAIT_TIMEOUT - 1);
  localparam logic [1:0]     TURBO_35  = 2'b00;
  localparam logic [1:0]     TURBO_7   = 2'b01;

  logic [2:0]    cnt;
  logic [CW-1:0] wait_cnt;
  logic          tick;
  logic          timeout;
  logic          hold;
  logic          do_rise;
  logic          do_fall;
  logic          suppress;
  logic          forced;

  // Strobes are pure decodes of the registered phase counter: glitch-free and
  // all asserted together on cnt==7.
  assign ck14 = cnt[0];
  assign ck7  = &cnt[1:0];
  assign ck35 = &cnt;

  // Select the CPU toggle opportunity for the speed currently in effect.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    tick = 1'b1;
    case (turbo_active)
      TURBO_35: tick = ck7;
      TURBO_7:  tick = ck14;
      default:  tick = 1'b1;
    endcase
  end

  // Toggle decisions for this clk28 edge. A rise is never held back; a fall is
  // suppressed while the wait is honoured.
  assign timeout  = (wait_cnt == WAIT_LAST);
  assign hold     = wait_req && !timeout;
  assign do_rise  = tick && !clkcpu;
  assign do_fall  = tick &&  clkcpu && !hold;
  assign suppress = tick &&  clkcpu &&  hold;
  assign forced   = do_fall && wait_req && timeout;

  // Free-running phase counter, wraps 7 -> 0.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) cnt <= 3'd0;
    else        cnt <= cnt + 3'd1;
  end

  // CPU clock, its edge strobes, and the speed latch (only updated on a fall,
  // so a new rate never shortens a high phase).
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      clkcpu       <= 1'b0;
      cpu_rise     <= 1'b0;
      cpu_fall     <= 1'b0;
      turbo_active <= TURBO_35;
    end else begin
      cpu_rise <= do_rise;
      cpu_fall <= do_fall;
      if (do_rise) clkcpu <= 1'b1;
      if (do_fall) begin
        clkcpu       <= 1'b0;
        turbo_active <= turbo_req;
      end
    end
  end

  // Wait tracking: wait_active marks a suppressed fall; wait_cnt measures the
  // hold and stays saturated until wait_req drops, so one long request can
  // only stall the CPU once.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      wait_active <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (!wait_req || do_fall) wait_active <= 1'b0;
      else if (suppress)        wait_active <= 1'b1;

      if (!wait_req)                         wait_cnt <= '0;
      else if (wait_active && !timeout)      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a forced release in the same cycle as clr_err wins.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)       wait_err <= 1'b0;
    else if (forced)  wait_err <= 1'b1;
    else if (clr_err) wait_err <= 1'b0;
  end

endmodule

// File: doc/cpu_clk_gen.md
Name: cpu_clk_gen

Overview:
- Generates the CPU clock and the shared clock-enable strobes (ck14, ck7, ck35) from clk28.
- Sits directly upstream of the SD/SPI interface: it feeds that block's ck14/ck7 enables.
- Also sits directly downstream of it: it consumes the interface's wait request (div_wait) and stretches the CPU clock until the SPI transfer completes.
- Supports 3.5/7/14 MHz turbo modes with glitch-free switching and a wait-timeout safety net.

Parameters:
- WAIT_TIMEOUT, 255, maximum clk28 cycles clkcpu may be held high by wait_req before forced release (1..1023).

Ports:
- clk28  in  1  28 MHz system clock
- rst_n  in  1  reset, asynchronous, active-low
- turbo_req  in  2  requested speed: 00=3.5 MHz, 01=7 MHz, 10/11=14 MHz
- wait_req  in  1  hold request (div_wait OR other wait sources), level, synchronous to clk28
- clr_err  in  1  single-cycle pulse, clears wait_err
- ck14  out  1  strobe, high 1 of every 2 clk28 cycles
- ck7  out  1  strobe, high 1 of every 4 clk28 cycles
- ck35  out  1  strobe, high 1 of every 8 clk28 cycles
- clkcpu  out  1  CPU clock, registered
- cpu_rise  out  1  high for the clk28 cycle in which clkcpu has just become 1
- cpu_fall  out  1  high for the clk28 cycle in which clkcpu has just become 0
- turbo_active  out  2  speed currently in effect
- wait_active  out  1  clkcpu currently being held by wait_req
- wait_err  out  1  sticky, a wait timeout has occurred

Behaviour:

Reset values:
- cnt=0, clkcpu=0, cpu_rise=0, cpu_fall=0, turbo_active=00, wait_cnt=0, wait_active=0, wait_err=0.
- ck14/ck7/ck35 are all 0 in reset, because they decode cnt=0.

Phase counter and strobes:
- cnt is a 3-bit free-running counter, +1 per clk28, wraps 7→0.
- ck14 = cnt[0].
- ck7 = (cnt[1:0]==3).
- ck35 = (cnt==7).
- Strobes are pure decodes of the registered cnt, so they are glitch-free and coincident with each other.
- First clk28 edge after reset: cnt=1, so ck14=1 and ck7=ck35=0.

Tick select:
- turbo_active 00 uses tick=ck7.
- turbo_active 01 uses tick=ck14.
- turbo_active 1x uses tick=1.
- clkcpu half-period is therefore 4/2/1 clk28 cycles (3.5/7/14 MHz).

Toggle rule, evaluated at each clk28 edge where tick=1:
- If clkcpu=0: clkcpu←1 unconditionally.
- If clkcpu=1 and hold=0: clkcpu←0.
- If clkcpu=1 and hold=1: clkcpu stays 1.
- hold = wait_req && !timeout.
- Consequence: clkcpu never falls while wait is honoured. A wait arriving in the low phase lets the pending rising edge occur, then holds.

Edge strobes:
- cpu_rise/cpu_fall are registered alongside clkcpu.
- Exactly one pulse per edge. Never both high in the same cycle.

Wait counter:
- wait_active = clkcpu && wait_req && tick-blocked. It is registered: set on the cycle a fall was suppressed, cleared on release.
- wait_cnt increments each clk28 while wait_active. It saturates at WAIT_TIMEOUT-1.
- wait_cnt is cleared the cycle wait_req is sampled low.
- timeout = (wait_cnt == WAIT_TIMEOUT-1).
- On timeout, the next tick produces the fall regardless of wait_req, and wait_err←1.
- wait_cnt stays saturated until wait_req drops, so one long request cannot stall the CPU twice.

wait_err:
- Cleared by clr_err.
- If timeout and clr_err occur in the same cycle, set wins.

Turbo switching:
- turbo_active←turbo_req only on the clk28 edge that produces a clkcpu falling edge.
- Never during the high phase, and never while held.
- The new rate governs the following rising edge.
- The first low phase after a switch may be 1..4 clk28 cycles (minimum 1). No runt high phase ever occurs.
- turbo_req changes between falls: only the value present at the fall edge is used.

Simultaneous events:
- wait_req deasserting on a tick cycle while clkcpu=1 gives a fall on that same edge.
- Changes to turbo_req while held take effect at the release fall.

Reset mid-operation:
- Asynchronous return to reset values within the same cycle.
- clkcpu goes low immediately. Any wait in progress is abandoned without setting wait_err.

Test Plan:
- Reset release, turbo_req=00, no wait → ck14 period 2, ck7 period 4, ck35 period 8; clkcpu period 8 (high 4/low 4); cpu_rise every 8 cycles.
- turbo_req 00→10 asserted while clkcpu high → no change until next fall; afterward clkcpu toggles every clk28; turbo_active=10 from that fall edge; no high phase <1 cycle.
- turbo 01, wait_req raised in low phase for 20 cycles → one rise, clkcpu held high ~20 cycles, wait_active=1, fall on first ck14 after wait_req drops; wait_err=0.
- WAIT_TIMEOUT=16, wait_req held 100 cycles → forced fall at first tick after 16 held cycles; wait_err=1 until clr_err pulse; no second stall during same request.
- clr_err and timeout in same cycle → wait_err=1.
- Assert rst_n low during hold in turbo 10 → clkcpu=0, turbo_active=00, wait_err=0, strobes 0 immediately; normal 3.5 MHz after release.
